// File: rtl/reloj_pkg.sv
// reloj_pkg: shared encodings for the clock/date/timer edit path.
//   - modo encodings (hora/fecha/timer, 11 reserved -> hora)
//   - edit FSM state encoding
//   - BCD field bounds
//   - cs_vec/hold_vec bit indices (also the flat index of each count register)
//   - helpers: per-mode register mask, days-per-month for the month limit
package reloj_pkg;

  typedef enum logic [1:0] {
    MODO_HORA  = 2'b00,
    MODO_FECHA = 2'b01,
    MODO_TIMER = 2'b10,
    MODO_RSV   = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    EDIT   = 2'b10,
    COMMIT = 2'b11
  } estado_e;

  localparam logic [7:0] SEG_MIN  = 8'h00;
  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] HORA_MIN = 8'h00;
  localparam logic [7:0] DIA_MIN  = 8'h01;
  localparam logic [7:0] DIA_MAX  = 8'h31;
  localparam logic [7:0] MES_MIN  = 8'h01;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] ANIO_MIN = 8'h00;

  // Register index == bit position in cs_vec/hold_vec == modo*3 + campo.
  localparam logic [3:0] IDX_SEG_HORA   = 4'd0;
  localparam logic [3:0] IDX_MIN_HORA   = 4'd1;
  localparam logic [3:0] IDX_HORA_HORA  = 4'd2;
  localparam logic [3:0] IDX_DIA        = 4'd3;
  localparam logic [3:0] IDX_MES        = 4'd4;
  localparam logic [3:0] IDX_JAHR       = 4'd5;
  localparam logic [3:0] IDX_SEG_TIMER  = 4'd6;
  localparam logic [3:0] IDX_MIN_TIMER  = 4'd7;
  localparam logic [3:0] IDX_HORA_TIMER = 4'd8;

  // Three adjacent bits owned by one mode.
  function automatic logic [8:0] mascara(input logic [1:0] m);
    return 9'b000000111 << ({2'b00, m} * 4'd3);
  endfunction

  // Last valid day (BCD) of a BCD month; year 00 counts as leap.
  function automatic logic [7:0] dias_mes(input logic [7:0] mes, input logic [7:0] jahr);
    logic [7:0] y;
    y = {4'b0000, jahr[7:4]} * 8'd10 + {4'b0000, jahr[3:0]};
    case (mes)
      8'h02:                      return (y[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/contador_bcd_campo.sv
// contador_bcd_campo: combinational two-digit BCD +/-1 with wrap.
//   valor     in  8  current BCD value
//   sube      in  1  1 = increment, 0 = decrement
//   minimo    in  8  lowest legal value (BCD)
//   maximo    in  8  highest legal value (BCD)
//   resultado out 8  next value
// A non-BCD input collapses to minimo. Anything outside the range wraps as if
// it had been at the far end, so the field always lands back in range.
module contador_bcd_campo (
  input  logic [7:0] valor,
  input  logic       sube,
  input  logic [7:0] minimo,
  input  logic [7:0] maximo,
  output logic [7:0] resultado
);

  logic es_bcd;
  assign es_bcd = (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9);

  // Valid BCD orders the same as binary, so plain compares work for bounds.
  always_comb begin
    resultado = minimo;
    if (!es_bcd)
      resultado = minimo;
    else if (sube) begin
      if (valor >= maximo)           resultado = minimo;
      else if (valor[3:0] == 4'd9)   resultado = {valor[7:4] + 4'd1, 4'd0};
      else                           resultado = valor + 8'd1;
    end else begin
      if (valor <= minimo || valor > maximo) resultado = maximo;
      else if (valor[3:0] == 4'd0)   resultado = {valor[7:4] - 4'd1, 4'd9};
      else                           resultado = valor - 8'd1;
    end
  end

endmodule

// File: rtl/contador_ajuste.sv
// contador_ajuste: user-edit stage in front of the register bank.
// IDLE -> LOAD (copy cur_a/b/c into the mode's registers) -> EDIT (buttons
// adjust the field under campo) -> COMMIT (one-cycle fin_edit) -> IDLE.
// Ports:
//   clk, reset (async, active low)
//   en_edit         level, user editing
//   modo[1:0]       00 hora, 01 fecha, 10 timer, 11 -> hora
//   btn_up/down     +/-1 on active field; btn_izq/der previous/next field
//   cur_a/b/c       bank values of the selected mode's fields 0/1/2
//   count_*         nine BCD registers captured by the bank
//   cs_vec/hold_vec per-register select/hold, [8:0] = timer(h,m,s), jahr, mes, dia, hora(h,m,s)
//   campo           active field 0..2
//   fin_edit        one-cycle commit strobe
// Build option: LIMITE_MES_EN makes the dia range follow month/leap year and
// clamps dia when mes or jahr is edited.
module contador_ajuste
  import reloj_pkg::*;
#(
  parameter logic [7:0] ANIO_MAX = 8'h99,
  parameter logic [7:0] HORA_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_edit,
  input  logic [1:0] modo,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic [7:0] cur_a,
  input  logic [7:0] cur_b,
  input  logic [7:0] cur_c,
  output logic [7:0] count_seg_hora,
  output logic [7:0] count_min_hora,
  output logic [7:0] count_hora_hora,
  output logic [7:0] count_dia_fecha,
  output logic [7:0] count_mes_fecha,
  output logic [7:0] count_jahr_fecha,
  output logic [7:0] count_seg_timer,
  output logic [7:0] count_min_timer,
  output logic [7:0] count_hora_timer,
  output logic [8:0] cs_vec,
  output logic [8:0] hold_vec,
  output logic [1:0] campo,
  output logic       fin_edit
);

  localparam logic [8:0][7:0] CNT_RST = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                         8'h01, 8'h00, 8'h00, 8'h00};

  estado_e         estado;
  logic [1:0]      modo_q;
  logic [1:0]      modo_ef;
  logic [8:0][7:0] cnt;
  logic [3:0]      base, idx;
  logic [7:0]      f_min, f_max, dia_max, nuevo;
  logic            paso, mover;

  assign modo_ef = (modo == MODO_RSV) ? MODO_HORA : modo;
  assign base    = {2'b00, modo_q} * 4'd3;
  assign idx     = base + {2'b00, campo};
  // Up+down cancel; izq+der cancel; a value step beats a field move.
  assign paso    = btn_up ^ btn_down;
  assign mover   = btn_izq ^ btn_der;

`ifdef LIMITE_MES_EN
  logic [7:0] mes_n, jahr_n, dia_lim;
  assign dia_max = dias_mes(cnt[IDX_MES], cnt[IDX_JAHR]);
  // Bound seen after this cycle's edit, so dia clamps in the same cycle.
  assign mes_n   = (idx == IDX_MES)  ? nuevo : cnt[IDX_MES];
  assign jahr_n  = (idx == IDX_JAHR) ? nuevo : cnt[IDX_JAHR];
  assign dia_lim = dias_mes(mes_n, jahr_n);
`else
  assign dia_max = DIA_MAX;
`endif

  always_comb begin
    f_min = SEG_MIN;
    f_max = SEG_MAX;
    case (idx)
      IDX_HORA_HORA, IDX_HORA_TIMER: begin f_min = HORA_MIN; f_max = HORA_MAX; end
      IDX_DIA:                       begin f_min = DIA_MIN;  f_max = dia_max;  end
      IDX_MES:                       begin f_min = MES_MIN;  f_max = MES_MAX;  end
      IDX_JAHR:                      begin f_min = ANIO_MIN; f_max = ANIO_MAX; end
      default: ;
    endcase
  end

  contador_bcd_campo u_bcd (
    .valor     (cnt[idx]),
    .sube      (btn_up),
    .minimo    (f_min),
    .maximo    (f_max),
    .resultado (nuevo)
  );

  // modo is captured on the IDLE->LOAD edge so hold_vec is already correct
  // during LOAD; nothing after that looks at modo again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado   <= IDLE;
      modo_q   <= MODO_HORA;
      cnt      <= CNT_RST;
      campo    <= 2'd0;
      cs_vec   <= '0;
      hold_vec <= '0;
      fin_edit <= 1'b0;
    end else begin
      case (estado)
        IDLE: if (en_edit) begin
          estado   <= LOAD;
          modo_q   <= modo_ef;
          hold_vec <= mascara(modo_ef);
        end
        LOAD: begin
          cnt[base]        <= cur_a;
          cnt[base + 4'd1] <= cur_b;
          cnt[base + 4'd2] <= cur_c;
          campo            <= 2'd0;
          cs_vec           <= mascara(modo_q);
          estado           <= EDIT;
        end
        EDIT: begin
          if (!en_edit) begin
            estado   <= COMMIT;
            fin_edit <= 1'b1;
          end
          if (paso) begin
            cnt[idx] <= nuevo;
`ifdef LIMITE_MES_EN
            if ((idx == IDX_MES || idx == IDX_JAHR) && cnt[IDX_DIA] > dia_lim)
              cnt[IDX_DIA] <= dia_lim;
`endif
          end else if (mover) begin
            if (btn_der) campo <= (campo == 2'd2) ? 2'd0 : campo + 2'd1;
            else         campo <= (campo == 2'd0) ? 2'd2 : campo - 2'd1;
          end
        end
        COMMIT: begin
          fin_edit <= 1'b0;
          cs_vec   <= '0;
          hold_vec <= '0;
          estado   <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign count_seg_hora   = cnt[IDX_SEG_HORA];
  assign count_min_hora   = cnt[IDX_MIN_HORA];
  assign count_hora_hora  = cnt[IDX_HORA_HORA];
  assign count_dia_fecha  = cnt[IDX_DIA];
  assign count_mes_fecha  = cnt[IDX_MES];
  assign count_jahr_fecha = cnt[IDX_JAHR];
  assign count_seg_timer  = cnt[IDX_SEG_TIMER];
  assign count_min_timer  = cnt[IDX_MIN_TIMER];
  assign count_hora_timer = cnt[IDX_HORA_TIMER];

endmodule

// File: tb/tb_contador_ajuste.sv
// Testbench for contador_ajuste: a driver applies stimulus at the falling edge
// and pushes the expected post-edge outputs from a decimal-arithmetic model;
// a monitor pops and compares one entry after every rising edge.
module tb_contador_ajuste;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_edit = 1'b0;
  logic [1:0] modo = 2'd0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_izq = 1'b0, btn_der = 1'b0;
  logic [7:0] cur_a = 8'h00, cur_b = 8'h00, cur_c = 8'h00;
  logic [7:0] count_seg_hora, count_min_hora, count_hora_hora;
  logic [7:0] count_dia_fecha, count_mes_fecha, count_jahr_fecha;
  logic [7:0] count_seg_timer, count_min_timer, count_hora_timer;
  logic [8:0] cs_vec, hold_vec;
  logic [1:0] campo;
  logic       fin_edit;

  contador_ajuste dut (
    .clk(clk), .reset(reset), .en_edit(en_edit), .modo(modo),
    .btn_up(btn_up), .btn_down(btn_down), .btn_izq(btn_izq), .btn_der(btn_der),
    .cur_a(cur_a), .cur_b(cur_b), .cur_c(cur_c),
    .count_seg_hora(count_seg_hora), .count_min_hora(count_min_hora),
    .count_hora_hora(count_hora_hora), .count_dia_fecha(count_dia_fecha),
    .count_mes_fecha(count_mes_fecha), .count_jahr_fecha(count_jahr_fecha),
    .count_seg_timer(count_seg_timer), .count_min_timer(count_min_timer),
    .count_hora_timer(count_hora_timer),
    .cs_vec(cs_vec), .hold_vec(hold_vec), .campo(campo), .fin_edit(fin_edit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] cnt;
    logic [8:0]  cs;
    logic [8:0]  hold;
    logic [1:0]  campo;
    logic        fin;
  } snap_t;

  snap_t expq[$];
  snap_t mon_e;
  int checks = 0, failures = 0;

  logic [71:0] dut_cnt;
  assign dut_cnt = {count_seg_hora, count_min_hora, count_hora_hora,
                    count_dia_fecha, count_mes_fecha, count_jahr_fecha,
                    count_seg_timer, count_min_timer, count_hora_timer};

  localparam logic [71:0] CNT_RST = {8'h00, 8'h00, 8'h00, 8'h01, 8'h01,
                                     8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 load, 2 edit, 3 commit. Registers indexed as mode*3+field.
  logic [7:0] m_reg [9];
  int m_ph = 0, m_mq = 0, m_campo = 0;

  logic       s_rst = 1'b0, s_en = 1'b0;
  logic       s_up = 1'b0, s_dn = 1'b0, s_iz = 1'b0, s_de = 1'b0;
  logic [1:0] s_modo = 2'd0;
  logic [7:0] s_a = 8'h00, s_b = 8'h00, s_c = 8'h00;

  function automatic bit es_bcd(logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction
  function automatic int a_dec(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic logic [7:0] a_bcd(int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction
  function automatic int dias(logic [7:0] mes, logic [7:0] jahr);
    if (!es_bcd(mes)) return 31;
    case (a_dec(mes))
      2:           return (a_dec(jahr) % 4 == 0) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction
  function automatic int fmin(int i);
    return (i == 3 || i == 4) ? 1 : 0;
  endfunction
  function automatic int fmax(int i);
    case (i)
      2, 8: return 23;
`ifdef LIMITE_MES_EN
      3:    return dias(m_reg[4], m_reg[5]);
`else
      3:    return 31;
`endif
      4:    return 12;
      5:    return 99;
      default: return 59;
    endcase
  endfunction

  task automatic edit_field(int i, bit up);
    int lo, hi, d;
    lo = fmin(i);
    hi = fmax(i);
    if (!es_bcd(m_reg[i])) m_reg[i] = a_bcd(lo);
    else begin
      d = a_dec(m_reg[i]);
      if (up) d = (d >= hi) ? lo : d + 1;
      else    d = (d <= lo || d > hi) ? hi : d - 1;
      m_reg[i] = a_bcd(d);
    end
`ifdef LIMITE_MES_EN
    if ((i == 4 || i == 5) && m_reg[3] > a_bcd(dias(m_reg[4], m_reg[5])))
      m_reg[3] = a_bcd(dias(m_reg[4], m_reg[5]));
`endif
  endtask

  task automatic model_step();
    if (!s_rst) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_reg[3] = 8'h01;
      m_reg[4] = 8'h01;
      m_ph = 0; m_mq = 0; m_campo = 0;
    end else begin
      case (m_ph)
        0: if (s_en) begin m_ph = 1; m_mq = (s_modo == 2'd3) ? 0 : int'(s_modo); end
        1: begin
          m_reg[3*m_mq] = s_a; m_reg[3*m_mq+1] = s_b; m_reg[3*m_mq+2] = s_c;
          m_campo = 0; m_ph = 2;
        end
        2: begin
          if (!s_en) m_ph = 3;
          if (s_up != s_dn) edit_field(3*m_mq + m_campo, s_up);
          else if (s_iz != s_de) m_campo = s_de ? (m_campo + 1) % 3 : (m_campo + 2) % 3;
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    logic [8:0] mask;
    mask = 9'h007 << (3 * m_mq);
    s.cnt   = {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4],
               m_reg[5], m_reg[6], m_reg[7], m_reg[8]};
    s.hold  = (m_ph != 0) ? mask : 9'h000;
    s.cs    = (m_ph >= 2) ? mask : 9'h000;
    s.campo = 2'(m_campo);
    s.fin   = (m_ph == 3);
    return s;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic tick();
    @(negedge clk);
    reset = s_rst; en_edit = s_en; modo = s_modo;
    btn_up = s_up; btn_down = s_dn; btn_izq = s_iz; btn_der = s_de;
    cur_a = s_a; cur_b = s_b; cur_c = s_c;
    model_step();
    expq.push_back(model_snap());
    s_up = 0; s_dn = 0; s_iz = 0; s_de = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("counts", dut_cnt, 72'(mon_e.cnt));
      chk("cs_vec", 72'(cs_vec), 72'(mon_e.cs));
      chk("hold_vec", 72'(hold_vec), 72'(mon_e.hold));
      chk("campo", 72'(campo), 72'(mon_e.campo));
      chk("fin_edit", 72'(fin_edit), 72'(mon_e.fin));
    end
  end

  function automatic logic [7:0] rnd_field(int i);
    if ($urandom_range(0, 7) == 0)
      return {4'($urandom_range(10, 15)), 4'($urandom_range(0, 9))};
    return a_bcd(int'($urandom_range(fmin(i), (i == 3) ? 31 : fmax(i))));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, r, mq;

    s_rst = 0; tick(); tick();
    after_edge();
    chk("reset_counts", dut_cnt, CNT_RST);
    chk("reset_cs_hold", {54'd0, cs_vec, hold_vec}, 72'd0);
    s_rst = 1;

    // hora: load 58 / 30 / 00
    s_modo = 2'd0; s_a = 8'h58; s_b = 8'h30; s_c = 8'h00; s_en = 1;
    tick(); tick();
    after_edge();
    chk("load_seg", 72'(count_seg_hora), 72'h58);
    chk("load_hold", 72'(hold_vec), 72'h007);
    chk("load_cs", 72'(cs_vec), 72'h007);
    s_up = 1; tick();
    s_up = 1; tick(); after_edge();
    chk("seg_wrap_up", 72'(count_seg_hora), 72'h00);
    s_dn = 1; tick(); after_edge();
    chk("seg_wrap_dn", 72'(count_seg_hora), 72'h59);
    s_de = 1; tick(); s_de = 1; tick(); after_edge();
    chk("campo_2", 72'(campo), 72'd2);
    s_dn = 1; tick(); after_edge();
    chk("hora_wrap_dn", 72'(count_hora_hora), 72'h23);
    s_en = 0; tick(); after_edge();
    chk("fin_high", 72'(fin_edit), 72'd1);
    tick(); after_edge();
    chk("fin_low", 72'(fin_edit), 72'd0);
    chk("commit_clear", {54'd0, cs_vec, hold_vec}, 72'd0);

    // fecha: navigation and month change, two years
    for (int k = 0; k < 2; k++) begin
      s_modo = 2'd1; s_a = 8'h31; s_b = 8'h01; s_c = (k == 0) ? 8'h24 : 8'h23; s_en = 1;
      tick(); tick();
      s_de = 1; tick(); after_edge(); chk("nav_der1", 72'(campo), 72'd1);
      s_de = 1; tick(); after_edge(); chk("nav_der2", 72'(campo), 72'd2);
      s_de = 1; tick(); after_edge(); chk("nav_der0", 72'(campo), 72'd0);
      s_iz = 1; tick(); after_edge(); chk("nav_izq2", 72'(campo), 72'd2);
      s_iz = 1; tick();
      s_up = 1; s_de = 1; tick(); after_edge();
      chk("upder_mes", 72'(count_mes_fecha), 72'h02);
      chk("upder_campo", 72'(campo), 72'd1);
`ifdef LIMITE_MES_EN
      chk("dia_clamp", 72'(count_dia_fecha), (k == 0) ? 72'h29 : 72'h28);
`else
      chk("dia_noclamp", 72'(count_dia_fecha), 72'h31);
`endif
      s_en = 0; tick(); tick();
    end

    // reset during EDIT
    s_modo = 2'd2; s_a = 8'h10; s_b = 8'h20; s_c = 8'h05; s_en = 1;
    tick(); tick(); s_up = 1; tick();
    s_rst = 0; tick(); after_edge();
    chk("midreset_counts", dut_cnt, CNT_RST);
    chk("midreset_vecs", {52'd0, cs_vec, hold_vec, campo}, 72'd0);
    chk("midreset_fin", 72'(fin_edit), 72'd0);
    s_rst = 1; s_en = 0; tick(); after_edge();
    chk("midreset_nofin", 72'(fin_edit), 72'd0);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      s_modo = 2'($urandom_range(0, 3));
      mq = (s_modo == 2'd3) ? 0 : int'(s_modo);
      s_a = rnd_field(3*mq); s_b = rnd_field(3*mq + 1); s_c = rnd_field(3*mq + 2);
      s_en = 1; tick();
      if ($urandom_range(0, 9) == 0) s_en = 0;
      tick();
      n = (s_en) ? int'($urandom_range(5, 30)) : 0;
      for (int c = 0; c < n; c++) begin
        r = int'($urandom_range(0, 15));
        s_up = (r inside {0, 1, 2, 8, 9});
        s_dn = (r inside {3, 4, 8, 10});
        s_iz = (r inside {5, 9, 11});
        s_de = (r inside {6, 10, 11});
        if ($urandom_range(0, 7) == 0) s_modo = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 60) == 0) s_rst = 0;
        tick();
        s_rst = 1;
      end
      s_en = 0; tick(); tick();
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick(); tick();
    for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
